// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence detectors it feeds.
// PARITY_EN (when defined) adds an even-parity bit to every frame.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

`ifdef PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  // Number of bits on the line per frame, including the optional parity bit.
  function automatic int frame_len(input int width);
    return width + (PARITY_ON ? 1 : 0);
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Load/shift register for one serial frame, tapped at the MSB.
// With PARITY_EN defined the even-parity bit is appended below the data LSB.
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             next_msb
);
  import serial_pkg::*;

  localparam int L = frame_len(WIDTH);

  logic [L-1:0] sreg_q;
  logic [L-1:0] sreg_d;
  logic [L-1:0] frame;

  always_comb begin
`ifdef PARITY_EN
    frame = {data_in, ^data_in};
`else
    frame = data_in;
`endif
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = frame;
    end else if (shift) begin
      sreg_d = {sreg_q[L-2:0], 1'b0};
    end
  end

  // The top registers the bit that will be on the line next cycle, so expose the next MSB.
  assign next_msb = sreg_d[L-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a word on valid/ready, sends it MSB-first, then idles GAP_CYCLES.
// PARITY_EN (when defined) appends an even-parity bit, lengthening each frame by one.
//
// Handshake: ready is high only in IDLE and not in reset; a word is accepted on a rising
// edge where valid && ready. valid while ready is low is ignored and nothing is queued.
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);
  import serial_pkg::*;

  localparam int CW = $clog2(frame_len(WIDTH) + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(frame_len(WIDTH) - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          out_q, out_d;
  logic          accept;
  logic          load;
  logic          shift;
  logic          next_msb;

  tx_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .data_in (data_in),
    .next_msb(next_msb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    ready   = (state_q == ST_IDLE) && !reset;
    accept  = valid && ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          cnt_d   = CNT_LOAD;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        // Counter reaching zero means the last frame bit is on the line now.
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_d = (state_d == ST_SEND) ? next_msb : IDLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      out_q   <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_SEND) && (cnt_q == '0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: DUT a uses defaults, DUT b uses GAP_CYCLES=0, IDLE_LEVEL=1.
// PARITY_EN, when defined for the build, extends the expected frames with the parity bit.
module tb_serial_pattern_tx;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_out, a_busy, a_done;
  logic       b_ready, b_out, b_busy, b_done;
  logic [1:0] a_state, b_state;

  always #5 clk = ~clk;

  serial_pattern_tx #(
    .WIDTH(8), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data), .valid(a_valid), .ready(a_ready),
    .out(a_out), .busy(a_busy), .done(a_done), .state_dbg(a_state)
  );

  serial_pattern_tx #(
    .WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data), .valid(b_valid), .ready(b_ready),
    .out(b_out), .busy(b_busy), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits for one frame, MSB first, parity last when enabled.
  task automatic push_frame(input logic [7:0] word);
    for (int i = 7; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef PARITY_EN
    exp_q.push_back(^word);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Entered at the negedge of cycle k+1; leaves at the negedge of the first gap cycle.
  task automatic expect_frame_a(input string tag);
    while (exp_q.size() > 0) begin
      exp_bit = exp_q.pop_front();
      check({tag, "_out"},   a_out,   exp_bit);
      check({tag, "_done"},  a_done,  exp_q.size() == 0);
      check({tag, "_busy"},  a_busy,  1);
      check({tag, "_ready"}, a_ready, 0);
      @(negedge clk);
    end
  endtask

  // Checks the single gap cycle, then the idle cycle where ready returns.
  task automatic finish_a(input string tag);
    check({tag, "_gap_out"},   a_out,   0);
    check({tag, "_gap_busy"},  a_busy,  1);
    check({tag, "_gap_ready"}, a_ready, 0);
    check({tag, "_gap_done"},  a_done,  0);
    @(negedge clk);
    check({tag, "_idle_ready"}, a_ready, 1);
    check({tag, "_idle_busy"},  a_busy,  0);
    check({tag, "_idle_out"},   a_out,   0);
  endtask

  task automatic send_a(input string tag, input logic [7:0] word);
    a_data  = word;
    a_valid = 1'b1;
    #1;
    check({tag, "_ready_pre"}, a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    push_frame(word);
    expect_frame_a(tag);
    finish_a(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int i;
    reset   = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'hA5;
    b_valid = 1'b0;
    b_data  = 8'h00;

    // 1: reset held three cycles with valid high
    repeat (3) begin
      @(negedge clk);
      check("t1_ready", a_ready, 0);
      check("t1_out",   a_out,   0);
      check("t1_busy",  a_busy,  0);
      check("t1_done",  a_done,  0);
      check("t1_state", a_state, 2'd0);
      check("t1_b_out", b_out,   1);
    end
    reset = 1'b0;
    #1;
    check("t1_ready_rel", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    push_frame(8'hA5);
    expect_frame_a("t1");
    finish_a("t1");

    // 2: single frame 8'hCC
    send_a("t2", 8'hCC);

    // 3: valid held high across two words
    a_data  = 8'hCC;
    a_valid = 1'b1;
    @(negedge clk);
    a_data = 8'h0F;
    push_frame(8'hCC);
    expect_frame_a("t3a");
    finish_a("t3a");
    @(negedge clk);
    a_valid = 1'b0;
    push_frame(8'h0F);
    expect_frame_a("t3b");
    finish_a("t3b");

    // 4: reset in cycle k+4 aborts the frame
    a_data  = 8'hAA;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    push_frame(8'hAA);
    repeat (3) begin
      exp_bit = exp_q.pop_front();
      check("t4_out", a_out, exp_bit);
      @(negedge clk);
    end
    exp_bit = exp_q.pop_front();
    check("t4_out_k4", a_out, exp_bit);
    check("t4_done_k4", a_done, 0);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("t4_rst_out",   a_out,   0);
    check("t4_rst_busy",  a_busy,  0);
    check("t4_rst_done",  a_done,  0);
    check("t4_rst_ready", a_ready, 0);
    reset = 1'b0;
    #1;
    check("t4_ready_rel", a_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("t4_post_done", a_done, 0);
      check("t4_post_out",  a_out,  0);
    end

    // 5: parity-sensitive words
    send_a("t5a", 8'h07);
    send_a("t5b", 8'hCC);

    // 6: DUT b, no gap, idle level high, valid pulse mid-frame ignored
    check("t6_idle_out", b_out, 1);
    b_data  = 8'h3C;
    b_valid = 1'b1;
    #1;
    check("t6_ready_pre", b_ready, 1);
    @(negedge clk);
    b_valid = 1'b0;
    push_frame(8'h3C);
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 2) begin
        b_valid = 1'b1;
        b_data  = 8'hFF;
      end else begin
        b_valid = 1'b0;
      end
      exp_bit = exp_q.pop_front();
      check("t6_out",   b_out,   exp_bit);
      check("t6_done",  b_done,  exp_q.size() == 0);
      check("t6_busy",  b_busy,  1);
      check("t6_ready", b_ready, 0);
      @(negedge clk);
      i++;
    end
    b_valid = 1'b0;
    check("t6_ready_ret", b_ready, 1);
    check("t6_out_ret",   b_out,   1);
    check("t6_busy_ret",  b_busy,  0);
    check("t6_done_ret",  b_done,  0);
    @(negedge clk);
    check("t6_out_idle",  b_out,   1);
    check("t6_busy_idle", b_busy,  0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
